// File: rtl/ir_pkg.sv
// ir_pkg: shared default sizes and instruction word layout for ir_queue.
package ir_pkg;
  localparam int BUS_W_DEF = 16;
  localparam int OP_W_DEF = 4;
  localparam int DEPTH_DEF = 4;
  typedef struct packed {
    logic [OP_W_DEF-1:0] opcode;
    logic [BUS_W_DEF-OP_W_DEF-1:0] operand;
  } ir_word_t;
endpackage

// File: rtl/ir_fifo.sv
// ir_fifo: prefetch queue storage, wrapping head/tail pointers and occupancy count.
module ir_fifo #(
  parameter int W = 16,
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic          clr,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);
  logic [W-1:0] mem [DEPTH];
  logic [PW-1:0] head, tail;
  always_ff @(negedge clk or negedge rst_n)
    if (!rst_n) begin
      head <= '0;
      tail <= '0;
      count <= '0;
    end else if (clr) begin
      head <= '0;
      tail <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + PW'(1);
      if (pop) head <= head + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  // storage is never reset; count alone decides what is live
  always_ff @(negedge clk)
    if (push) mem[tail] <= din;
  assign dout = mem[head];
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
endmodule

// File: rtl/ir_queue.sv
// ir_queue: instruction prefetch queue feeding an instruction register, falling-edge clocked.
// Optional IR_PARITY_EN adds per-entry even parity and the ir_parity_err output.
module ir_queue
  import ir_pkg::*;
#(
  parameter int BUS_W = BUS_W_DEF,
  parameter int OP_W = OP_W_DEF,
  parameter int DEPTH = DEPTH_DEF,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [BUS_W-1:0]  bus,
  input  logic              advance,
  input  logic              flush,
  output logic [OP_W-1:0]   ir_opcode,
  output logic [BUS_W-OP_W-1:0] ir_operand,
  output logic              ir_valid,
  output logic [CW-1:0]     count,
  output logic              full,
  output logic              empty,
  output logic              overflow
`ifdef IR_PARITY_EN
  , output logic            ir_parity_err
`endif
);
`ifdef IR_PARITY_EN
  localparam int W = BUS_W + 1;
  logic [W-1:0] din;
  assign din = {^bus, bus};
`else
  localparam int W = BUS_W;
  logic [W-1:0] din;
  assign din = bus;
`endif
  logic [W-1:0] head;
  logic [BUS_W-1:0] ir;
  logic pop, push;
  assign pop = advance && !empty && !flush;
  // a full queue still accepts a word when the head leaves on the same edge
  assign push = load && !flush && (!full || advance);
  ir_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo (
    .clk(clk), .rst_n(rst_n), .push(push), .pop(pop), .clr(flush),
    .din(din), .dout(head), .count(count), .full(full), .empty(empty)
  );
  always_ff @(negedge clk or negedge rst_n)
    if (!rst_n) begin
      ir <= '0;
      ir_valid <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (pop) ir <= head[BUS_W-1:0];
      ir_valid <= flush ? 1'b0 : advance ? !empty : ir_valid;
      overflow <= flush ? 1'b0 : (load && full && !advance) ? 1'b1 : overflow;
    end
`ifdef IR_PARITY_EN
  always_ff @(negedge clk or negedge rst_n)
    if (!rst_n) ir_parity_err <= 1'b0;
    else ir_parity_err <= flush ? 1'b0 : pop ? ^head : ir_parity_err;
`endif
  assign ir_opcode = ir[BUS_W-1 -: OP_W];
  assign ir_operand = ir[BUS_W-OP_W-1:0];
endmodule

// File: tb/tb_ir_queue.sv
// tb_ir_queue: directed-vector bench for ir_queue; define IR_PARITY_EN to cover parity.
module tb_ir_queue;
  import ir_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic load = 1'b0, advance = 1'b0, flush = 1'b0;
  logic [15:0] bus = '0;
  logic [3:0] ir_opcode;
  logic [11:0] ir_operand;
  logic ir_valid, full, empty, overflow;
  logic [2:0] count;
  int vectors = 0, miscompares = 0;
`ifdef IR_PARITY_EN
  logic ir_parity_err;
`endif
  ir_queue dut (
    .clk(clk), .rst_n(rst_n), .load(load), .bus(bus), .advance(advance), .flush(flush),
    .ir_opcode(ir_opcode), .ir_operand(ir_operand), .ir_valid(ir_valid), .count(count),
    .full(full), .empty(empty), .overflow(overflow)
`ifdef IR_PARITY_EN
    , .ir_parity_err(ir_parity_err)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step(input logic l, input logic a, input logic f, input logic [15:0] b);
    load = l; advance = a; flush = f; bus = b;
    @(negedge clk);
    #1;
    load = 1'b0; advance = 1'b0; flush = 1'b0;
  endtask
  task automatic chk_state(input string tag, input logic [15:0] w, input logic v,
                           input logic [2:0] c, input logic ov);
    chk({tag, ".ir"}, {16'h0, ir_opcode, ir_operand}, {16'h0, w});
    chk({tag, ".valid"}, {31'h0, ir_valid}, {31'h0, v});
    chk({tag, ".count"}, {29'h0, count}, {29'h0, c});
    chk({tag, ".full"}, {31'h0, full}, {31'h0, c == 3'd4});
    chk({tag, ".empty"}, {31'h0, empty}, {31'h0, c == 3'd0});
    chk({tag, ".ovf"}, {31'h0, overflow}, {31'h0, ov});
  endtask
  initial begin
    ir_word_t w;
    #3;
    chk_state("reset", 16'h0000, 0, 0, 0);
    #4 rst_n = 1'b1;
    step(1, 0, 0, 16'h1234);
    chk_state("load1", 16'h0000, 0, 1, 0);
    step(0, 1, 0, 16'h0);
    w = 16'h1234;
    chk("adv1.opcode", {28'h0, ir_opcode}, {28'h0, w.opcode});
    chk("adv1.operand", {20'h0, ir_operand}, 32'h234);
    chk_state("adv1", 16'h1234, 1, 0, 0);
    step(0, 1, 0, 16'h0);
    chk_state("adv_empty", 16'h1234, 0, 0, 0);
    for (int i = 1; i <= 4; i++) step(1, 0, 0, 16'hA000 + 16'(i));
    chk_state("fill", 16'h1234, 0, 4, 0);
    step(1, 0, 0, 16'hA005);
    chk_state("overload", 16'h1234, 0, 4, 1);
    for (int i = 1; i <= 4; i++) begin
      step(0, 1, 0, 16'h0);
      chk_state($sformatf("drainA%0d", i), 16'hA000 + 16'(i), 1, 3'(4 - i), 1);
    end
    step(0, 0, 1, 16'h0);
    chk_state("flush", 16'hA004, 0, 0, 0);
    for (int i = 1; i <= 4; i++) step(1, 0, 0, 16'hC000 + 16'(i));
    step(1, 1, 0, 16'hB000);
    chk_state("full_ldadv", 16'hC001, 1, 4, 0);
    for (int i = 1; i <= 3; i++) begin
      step(1, 1, 0, 16'hB000 + 16'(i));
      chk_state($sformatf("wrap%0d", i), 16'hC001 + 16'(i), 1, 4, 0);
    end
    for (int i = 0; i <= 3; i++) begin
      step(0, 1, 0, 16'h0);
      chk_state($sformatf("drainB%0d", i), 16'hB000 + 16'(i), 1, 3'(3 - i), 0);
    end
    step(1, 1, 0, 16'hD00D);
    chk_state("empty_ldadv", 16'hB003, 0, 1, 0);
    step(1, 0, 0, 16'hD00E);
    step(1, 1, 1, 16'hD00F);
    chk_state("flush_prio", 16'hB003, 0, 0, 0);
    step(0, 1, 0, 16'h0);
    chk_state("flush_noload", 16'hB003, 0, 0, 0);
    step(1, 0, 0, 16'hE001);
    step(1, 1, 0, 16'hE002);
    for (int i = 3; i <= 6; i++) step(1, 0, 0, 16'hE000 + 16'(i));
    chk_state("pre_rst", 16'hE001, 1, 4, 1);
    #2 rst_n = 1'b0;
    #1;
    chk_state("async_rst", 16'h0000, 0, 0, 0);
    #1 rst_n = 1'b1;
    step(1, 0, 0, 16'hF00F);
    chk_state("post_rst_ld", 16'h0000, 0, 1, 0);
    step(0, 1, 0, 16'h0);
    chk_state("post_rst_adv", 16'hF00F, 1, 0, 0);
`ifdef IR_PARITY_EN
    #2 rst_n = 1'b0;
    #1 rst_n = 1'b1;
    step(1, 0, 0, 16'h0001);
    step(1, 0, 0, 16'h0003);
    dut.u_fifo.mem[0][16] = ~dut.u_fifo.mem[0][16];
    step(0, 1, 0, 16'h0);
    chk("par_bad", {31'h0, ir_parity_err}, 32'h1);
    chk_state("par_bad", 16'h0001, 1, 1, 0);
    step(0, 1, 0, 16'h0);
    chk("par_clean", {31'h0, ir_parity_err}, 32'h0);
    chk_state("par_clean", 16'h0003, 1, 0, 0);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/ir_queue.md
IR_QUEUE -- requirements
Module: ir_queue

Interface
REQ-001 Parameter BUS_W, default 16, SHALL set the internal bus and instruction word width.
REQ-002 Parameter OP_W, default 4, SHALL set the opcode width (1 <= OP_W < BUS_W).
REQ-003 Parameter DEPTH, default 4, SHALL set the prefetch queue depth (power of two, >= 2).
REQ-004 clk  in  1  single clock; all state SHALL update on the falling edge.
REQ-005 rst_n  in  1  reset, asynchronous and active-low.
REQ-006 load  in  1  push the current bus word into the queue.
REQ-007 bus  in  BUS_W  internal data bus.
REQ-008 advance  in  1  pop the queue head into the instruction register (IR).
REQ-009 flush  in  1  discard queue and IR contents (branch taken).
REQ-010 ir_opcode  out  OP_W  IR bits [BUS_W-1:BUS_W-OP_W].
REQ-011 ir_operand  out  BUS_W-OP_W  IR bits [BUS_W-OP_W-1:0].
REQ-012 ir_valid  out  1  IR holds a live instruction.
REQ-013 count  out  $clog2(DEPTH+1)  queued entries, excluding the IR.
REQ-014 full / empty  out  1 each  count==DEPTH / count==0.
REQ-015 overflow  out  1  sticky flag: a load was dropped.

Function
REQ-016 Load with !full SHALL write bus to the tail and increment count; the word SHALL be poppable from the next falling edge (no bypass).
REQ-017 Load with full and no advance SHALL drop the word, leave the queue unchanged, and set overflow.
REQ-018 Advance with !empty SHALL copy the head into the IR, set ir_valid, and decrement count.
REQ-019 Advance with empty SHALL clear ir_valid and hold the IR bits unchanged.
REQ-020 Load and advance on the same edge with !empty SHALL both succeed, leaving count unchanged; this includes the full case.
REQ-021 Load and advance on the same edge with empty SHALL enqueue the word and clear ir_valid.
REQ-022 Flush SHALL have priority over load and advance, and SHALL zero count and clear ir_valid and overflow; IR bits hold.
REQ-023 Head and tail pointers SHALL wrap modulo DEPTH.
REQ-024 Outputs SHALL be registered or derived from registers only, with no combinational path from inputs.

Reset
REQ-025 Asserting rst_n low SHALL immediately set IR=0, ir_valid=0, count=0, empty=1, full=0, overflow=0, and both pointers to 0, including during an operation in progress.
REQ-026 The first falling edge after rst_n deassertion SHALL act on inputs normally.
REQ-027 Queue storage contents SHALL NOT require reset.

Configuration
REQ-028 When IR_PARITY_EN is defined, each entry SHALL store an even-parity bit computed from bus at load.
REQ-029 When IR_PARITY_EN is defined, output ir_parity_err (1 bit) SHALL be set when an entry popped into the IR fails the parity check, and SHALL be cleared by the next successful advance, by flush, or by reset.
REQ-030 When IR_PARITY_EN is undefined, neither the parity storage nor the ir_parity_err port SHALL exist.

Structure
REQ-031 Shared package ir_pkg SHALL hold the default BUS_W/OP_W/DEPTH constants and an ir_word_t struct {opcode, operand}.
REQ-032 Queue storage and pointers SHALL live in sub-module ir_fifo; ir_queue SHALL own the IR, ir_valid, overflow and parity logic.

Verification
REQ-033 Reset, then load 0x1234, then advance -> ir_opcode=0x1, ir_operand=0x234, ir_valid=1, count=0.
REQ-034 Load 0xA001..0xA004, then load 0xA005 -> full=1, overflow=1, count=4; four advances yield 0xA001..0xA004 in order.
REQ-035 Full queue, simultaneous load 0xB000 + advance -> count=4, overflow=0, 0xB000 is the last word popped; 3 further load/advance pairs exercise pointer wrap.
REQ-036 Queue holding 2 entries, flush together with load and advance -> count=0, ir_valid=0, overflow=0, load ignored.
REQ-037 rst_n low mid-sequence between clock edges -> all outputs reach reset values without a clock edge.
REQ-038 With IR_PARITY_EN defined, force a parity bit flip on the entry holding 0x0001, then advance -> ir_parity_err=1; next clean advance -> 0.
